// File: rtl/avalon_pio_master_pkg.sv
// Shared definitions for avalon_pio_master: FSM encoding and the legal slave read latencies.
package avalon_pio_master_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam int READ_LATENCY_MIN = 0;
    localparam int READ_LATENCY_MAX = 1;

    function automatic bit read_latency_legal(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/pio_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry an extra wrap bit.
module pio_cmd_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Same index with opposite wrap bits means the write pointer has lapped the read pointer.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/avalon_pio_master.sv
// Single-beat Avalon-MM master issuing queued PIO reads/writes one at a time, with in-order read responses.
// Define AVALON_PIO_MASTER_TIMEOUT_EN to abandon transfers stalled by waitrequest for TIMEOUT_CYCLES cycles.
module avalon_pio_master
    import avalon_pio_master_pkg::*;
#(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read_n,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy
);
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
    } cmd_t;

    // An out-of-range latency falls back to capturing on the accept edge.
    localparam bit RD_WAIT = read_latency_legal(READ_LATENCY) && (READ_LATENCY == READ_LATENCY_MAX);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d, cmd_in, fifo_head;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              to_expire;

    assign cmd_in    = {cmd_write, cmd_address, cmd_writedata};
    assign cmd_ready = !fifo_full && !reset;
    assign fifo_push = cmd_valid && cmd_ready;

    pio_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (cmd_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    // Expires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
    assign to_expire = (state_q == ISSUE) && avm_waitrequest &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_error = err_q;

    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (fifo_pop) begin
            to_cnt_d = '0;
            err_d    = 1'b0;
        end else if ((state_q == ISSUE) && avm_waitrequest) begin
            to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
        if (to_expire) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    assign to_expire = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        rdata_d  = rdata_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_head;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    if (cmd_q.write) begin
                        state_d = IDLE;
                    end else if (RD_WAIT) begin
                        state_d = WAIT_RD;
                    end else begin
                        rdata_d = avm_readdata;
                        state_d = RESP;
                    end
                end else if (to_expire) begin
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            WAIT_RD: begin
                rdata_d = avm_readdata;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes only in ISSUE; address and data keep showing the last command.
    assign avm_chipselect = (state_q == ISSUE);
    assign avm_write_n    = !((state_q == ISSUE) && cmd_q.write);
    assign avm_read_n     = !((state_q == ISSUE) && !cmd_q.write);
    assign avm_address    = cmd_q.address;
    assign avm_writedata  = cmd_q.writedata;

    assign rsp_valid    = (state_q == RESP);
    assign rsp_readdata = rdata_q;
    assign busy         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_avalon_pio_master.sv
// Self-checking bench for avalon_pio_master: directed scenarios plus a randomized run against an in-order register model.
module tb_avalon_pio_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic        cmdWrite = 1'b0;
    logic [1:0]  cmdAddress = 2'd0;
    logic [31:0] cmdWritedata = 32'h0;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [31:0] rspReaddata;
    logic        rspError;
    logic [1:0]  avmAddress;
    logic        avmChipselect;
    logic        avmReadN;
    logic        avmWriteN;
    logic [31:0] avmWritedata;
    logic [31:0] avmReaddata;
    logic        avmWaitrequest = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;

    // Slave register file and the bench's own model of what it should contain.
    logic [31:0] slvRegs   [4] = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444};
    logic [31:0] modelRegs [4] = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444};
    logic [31:0] slvNext;
    logic [34:0] busLog [$];
    logic [34:0] expBus [$];
    logic [31:0] expRsp [$];
    int          busChecked = 0;

    int          firstIssue, firstValid, strobeCnt, rspSeen, nBus, nRsp, randCmds, waited;
    logic [31:0] expData, holdData;

    avalon_pio_master #(
        .ADDR_W         (2),
        .DATA_W         (32),
        .FIFO_DEPTH     (4),
        .READ_LATENCY   (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmdValid),
        .cmd_ready       (cmdReady),
        .cmd_write       (cmdWrite),
        .cmd_address     (cmdAddress),
        .cmd_writedata   (cmdWritedata),
        .rsp_valid       (rspValid),
        .rsp_ready       (rspReady),
        .rsp_readdata    (rspReaddata),
        .rsp_error       (rspError),
        .avm_address     (avmAddress),
        .avm_chipselect  (avmChipselect),
        .avm_read_n      (avmReadN),
        .avm_write_n     (avmWriteN),
        .avm_writedata   (avmWritedata),
        .avm_readdata    (avmReaddata),
        .avm_waitrequest (avmWaitrequest),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Slave: an accept happens on the edge after a negedge that sees strobes with waitrequest low.
    // Read data is valid only in the following cycle; every other cycle carries noise.
    always @(negedge clk) begin
        slvNext = $urandom;
        if (!reset && avmChipselect && !avmWaitrequest) begin
            if (!avmWriteN) begin
                slvRegs[avmAddress] = avmWritedata;
                busLog.push_back({1'b1, avmAddress, avmWritedata});
            end else if (!avmReadN) begin
                slvNext = slvRegs[avmAddress];
                busLog.push_back({1'b0, avmAddress, 32'h0});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        avmReaddata = slvNext;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Commands execute strictly in order, so the model applies each one at acceptance.
    task automatic modelAccept(input logic w, input logic [1:0] a, input logic [31:0] d);
        if (w) begin
            modelRegs[a] = d;
            expBus.push_back({1'b1, a, d});
        end else begin
            expRsp.push_back(modelRegs[a]);
            expBus.push_back({1'b0, a, 32'h0});
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
        int n = 0;
        cmdValid = 1'b1;
        cmdWrite = w;
        cmdAddress = a;
        cmdWritedata = d;
        while (!cmdReady && n < 200) begin
            tick();
            n++;
        end
        if (cmdReady) begin
            modelAccept(w, a, d);
            tick();
        end else begin
            checkOutput("cmd_accept_wait", 64'(cmdReady), 64'(1));
        end
        cmdValid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(busy), 64'(0));
    endtask

    task automatic compareBus(input string tag);
        checkOutput({tag, "_count"}, 64'(busLog.size()), 64'(expBus.size()));
        for (int i = busChecked; i < busLog.size() && i < expBus.size(); i++)
            checkOutput({tag, "_entry"}, 64'(busLog[i]), 64'(expBus[i]));
        busChecked = busLog.size();
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) tick();
        checkOutput("rst_cmd_ready", 64'(cmdReady), 64'(0));
        checkOutput("rst_rsp_valid", 64'(rspValid), 64'(0));
        checkOutput("rst_rsp_data", 64'(rspReaddata), 64'(0));
        checkOutput("rst_rsp_error", 64'(rspError), 64'(0));
        checkOutput("rst_cs", 64'(avmChipselect), 64'(0));
        checkOutput("rst_read_n", 64'(avmReadN), 64'(1));
        checkOutput("rst_write_n", 64'(avmWriteN), 64'(1));
        checkOutput("rst_address", 64'(avmAddress), 64'(0));
        checkOutput("rst_writedata", 64'(avmWritedata), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        tick();
        checkOutput("post_rst_cmd_ready", 64'(cmdReady), 64'(1));

        // Single write without stalls: exactly one strobe cycle, right after the pop.
        applyStimulus(1'b1, 2'd0, 32'h00A1_B2C3);
        strobeCnt = 0; firstIssue = -1; rspSeen = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (avmChipselect) begin
                strobeCnt++;
                if (firstIssue < 0) firstIssue = k;
                checkOutput("wr_write_n", 64'(avmWriteN), 64'(0));
                checkOutput("wr_read_n", 64'(avmReadN), 64'(1));
                checkOutput("wr_data", 64'(avmWritedata), 64'(32'h00A1_B2C3));
                checkOutput("wr_addr", 64'(avmAddress), 64'(0));
            end
            if (rspValid) rspSeen++;
        end
        checkOutput("wr_strobe_cycles", 64'(strobeCnt), 64'(1));
        checkOutput("wr_first_cycle", 64'(firstIssue), 64'(1));
        checkOutput("wr_no_rsp", 64'(rspSeen), 64'(0));
        waitIdle("wr_idle");
        compareBus("wr_bus");

        // Latency-1 read held by rsp_ready low.
        applyStimulus(1'b1, 2'd0, 32'h0012_3456);
        waitIdle("rd_setup_idle");
        rspReady = 1'b0;
        applyStimulus(1'b0, 2'd0, $urandom);
        firstIssue = -1; firstValid = -1;
        for (int k = 1; k <= 8 && firstValid < 0; k++) begin
            tick();
            if (avmChipselect && firstIssue < 0) firstIssue = k;
            if (rspValid) firstValid = k;
        end
        checkOutput("rd_issue_cycle", 64'(firstIssue), 64'(1));
        checkOutput("rd_valid_cycle", 64'(firstValid), 64'(3));
        expData = (expRsp.size() > 0) ? expRsp.pop_front() : 32'hDEAD_0000;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rd_hold_valid", 64'(rspValid), 64'(1));
            checkOutput("rd_hold_data", 64'(rspReaddata), 64'(expData));
            checkOutput("rd_hold_err", 64'(rspError), 64'(0));
            tick();
        end
        checkOutput("rd_still_valid", 64'(rspValid), 64'(1));
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput("rd_consumed", 64'(rspValid), 64'(0));
        waitIdle("rd_idle");
        compareBus("rd_bus");

        // Write stalled 3 cycles: 4 stable strobe cycles, one accept.
        avmWaitrequest = 1'b1;
        holdData = $urandom;
        applyStimulus(1'b1, 2'd3, holdData);
        strobeCnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (avmChipselect) begin
                strobeCnt++;
                checkOutput("ws_addr", 64'(avmAddress), 64'(3));
                checkOutput("ws_data", 64'(avmWritedata), 64'(holdData));
                checkOutput("ws_write_n", 64'(avmWriteN), 64'(0));
                if (strobeCnt == 4) avmWaitrequest = 1'b0;
            end
        end
        avmWaitrequest = 1'b0;
        checkOutput("ws_strobe_cycles", 64'(strobeCnt), 64'(4));
        compareBus("ws_bus");

        // FIFO fill: one write stalled on the bus, four queued behind it, the fifth refused.
        avmWaitrequest = 1'b1;
        applyStimulus(1'b1, 2'd1, $urandom);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), $urandom);
            checkOutput("fifo_ready_after_push", 64'(cmdReady), 64'(i < 3));
        end
        holdData = $urandom;
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddress = 2'd2; cmdWritedata = holdData;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("fifo_full_hold", 64'(cmdReady), 64'(0));
        end
        avmWaitrequest = 1'b0;
        applyStimulus(1'b1, 2'd2, holdData);
        waitIdle("fifo_busy_fall");
        compareBus("fifo_bus");

        // Reset while a read is stalled in ISSUE with two more queued.
        avmWaitrequest = 1'b1;
        rspReady = 1'b0;
        nBus = expBus.size();
        nRsp = expRsp.size();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'(i), $urandom);
        tick();
        checkOutput("mr_pre_cs", 64'(avmChipselect), 64'(1));
        reset = 1'b1;
        tick();
        checkOutput("mr_cs", 64'(avmChipselect), 64'(0));
        checkOutput("mr_read_n", 64'(avmReadN), 64'(1));
        checkOutput("mr_write_n", 64'(avmWriteN), 64'(1));
        checkOutput("mr_busy", 64'(busy), 64'(0));
        checkOutput("mr_rsp_valid", 64'(rspValid), 64'(0));
        reset = 1'b0;
        avmWaitrequest = 1'b0;
        while (expBus.size() > nBus) void'(expBus.pop_back());
        while (expRsp.size() > nRsp) void'(expRsp.pop_back());
        repeat (10) tick();
        checkOutput("mr_after_busy", 64'(busy), 64'(0));
        compareBus("mr_bus");

        // Randomized traffic with random stalls and back-pressure.
        randCmds = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            avmWaitrequest = ($urandom_range(0, 3) == 0);
            rspReady = 1'($urandom_range(0, 1));
            if (rspValid && rspReady) begin
                checkOutput("rand_rsp_expected", 64'(expRsp.size() > 0), 64'(1));
                if (expRsp.size() > 0) begin
                    expData = expRsp.pop_front();
                    checkOutput("rand_rsp_data", 64'(rspReaddata), 64'(expData));
                    checkOutput("rand_rsp_err", 64'(rspError), 64'(0));
                end
            end
            if (randCmds < 48) begin
                cmdValid = 1'($urandom_range(0, 1));
                cmdWrite = 1'($urandom_range(0, 1));
                cmdAddress = 2'($urandom_range(0, 3));
                cmdWritedata = $urandom;
                if (cmdValid && cmdReady) begin
                    modelAccept(cmdWrite, cmdAddress, cmdWritedata);
                    randCmds++;
                end
            end else begin
                cmdValid = 1'b0;
                if (!busy) break;
            end
            tick();
        end
        cmdValid = 1'b0;
        avmWaitrequest = 1'b0;
        rspReady = 1'b0;
        checkOutput("rand_drained", 64'(busy), 64'(0));
        checkOutput("rand_rsp_left", 64'(expRsp.size()), 64'(0));
        compareBus("rand_bus");

`ifdef AVALON_PIO_MASTER_TIMEOUT_EN
        // Read stuck behind waitrequest must come back as an error response.
        avmWaitrequest = 1'b1;
        nBus = expBus.size();
        nRsp = expRsp.size();
        applyStimulus(1'b0, 2'd2, $urandom);
        waited = 0;
        while (!rspValid && waited < 60) begin
            tick();
            waited++;
        end
        checkOutput("to_rsp_valid", 64'(rspValid), 64'(1));
        checkOutput("to_rsp_error", 64'(rspError), 64'(1));
        checkOutput("to_rsp_data", 64'(rspReaddata), 64'(0));
        checkOutput("to_cs", 64'(avmChipselect), 64'(0));
        while (expBus.size() > nBus) void'(expBus.pop_back());
        while (expRsp.size() > nRsp) void'(expRsp.pop_back());
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        avmWaitrequest = 1'b0;
        checkOutput("to_consumed", 64'(rspValid), 64'(0));
        repeat (4) tick();
        compareBus("to_bus");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
